// File: rtl/npu_ldst_pkg.sv
// Shared definitions for the RF <-> SDRAM load/store engine.
package npu_ldst_pkg;

    // Engine sequencing states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_DATA  = 3'd2,
        RF_WR    = 3'd3,
        RF_RD    = 3'd4,
        RF_CAP   = 3'd5,
        WR_BURST = 3'd6,
        FIN      = 3'd7
    } ldst_state_e;

    // Burst count and beat counter are 8 bits wide, so a line can span at most 255 beats.
    localparam int LDST_CNT_W     = 8;
    localparam int LDST_MAX_BEATS = 255;

    // Number of Avalon beats needed to move one RF line.
    function automatic int ldst_beats(input int rf_data_w, input int sdram_data_w);
        return rf_data_w / sdram_data_w;
    endfunction

endpackage

// File: rtl/ldst_line_buf.sv
// One-line staging buffer plus the beat counter that walks its slices.
module ldst_line_buf
    import npu_ldst_pkg::*;
#(
    parameter int LINE_W  = 1408,
    parameter int SLICE_W = 128,
    parameter int BEATS   = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,    // restart the beat counter at slice 0
    input  logic               i_load,   // write i_slice at the current beat and advance
    input  logic [SLICE_W-1:0] i_slice,
    input  logic               i_cap,    // capture a whole line at once
    input  logic [LINE_W-1:0]  i_line,
    input  logic               i_adv,    // advance the beat counter without writing
    output logic               o_last,   // current beat is the final slice of the line
    output logic [LINE_W-1:0]  o_line,
    output logic [SLICE_W-1:0] o_slice
);

    logic [LDST_CNT_W-1:0] r_beat;
    logic [LINE_W-1:0]     r_line;

    assign o_last  = (r_beat == LDST_CNT_W'(BEATS - 1));
    assign o_line  = r_line;
    assign o_slice = r_line[r_beat*SLICE_W +: SLICE_W];

    // Beat counter wraps to 0 after the last slice so it is ready for the next line.
    // NOTE: clocked state uses <= so every flop samples pre-edge values; = here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else if (i_clr) begin
            r_beat <= '0;
        end else if (i_load || i_adv) begin
            r_beat <= o_last ? '0 : r_beat + LDST_CNT_W'(1);
        end
    end

    // Line storage: whole-line capture from the RF or slice-wise fill from Avalon.
    // NOTE: this wide buffer is deliberately cleared by reset so stale line data can never leak onto rf_d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line <= '0;
        end else if (i_cap) begin
            r_line <= i_line;
        end else if (i_load) begin
            r_line[r_beat*SLICE_W +: SLICE_W] <= i_slice;
        end
    end

endmodule

// File: rtl/rf_ldst_engine.sv
// rf_ldst_engine: moves strided lines between the register file and SDRAM using Avalon bursts.
module rf_ldst_engine
    import npu_ldst_pkg::*;
#(
    parameter int RF_ADDR_W    = 9,
    parameter int SDRAM_ADDR_W = 32,
    parameter int SDRAM_DATA_W = 128,
    parameter int RF_DATA_W    = 1408
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_store,
    input  logic [SDRAM_ADDR_W-1:0]   cmd_sdram_addr,
    input  logic [SDRAM_ADDR_W-1:0]   cmd_sdram_stride,
    input  logic [RF_ADDR_W-1:0]      cmd_rf_addr,
    input  logic [7:0]                cmd_line_num,
    output logic                      busy,
    output logic                      done,
    output logic [SDRAM_ADDR_W-1:0]   av_address,
    output logic                      av_read,
    output logic                      av_write,
    output logic [SDRAM_DATA_W-1:0]   av_writedata,
    output logic [SDRAM_DATA_W/8-1:0] av_byteenable,
    output logic [7:0]                av_burstcount,
    input  logic                      av_waitrequest,
    input  logic [SDRAM_DATA_W-1:0]   av_readdata,
    input  logic                      av_readdatavalid,
    output logic [RF_ADDR_W-1:0]      rf_addr,
    output logic [RF_DATA_W-1:0]      rf_d,
    output logic                      rf_we,
    output logic                      rf_re,
    input  logic [RF_DATA_W-1:0]      rf_q
);

    localparam int BEATS = ldst_beats(RF_DATA_W, SDRAM_DATA_W);

    if (RF_DATA_W % SDRAM_DATA_W != 0) begin : g_chk_ratio
        $error("rf_ldst_engine: RF_DATA_W must be a whole multiple of SDRAM_DATA_W");
    end
    if (BEATS < 1 || BEATS > LDST_MAX_BEATS) begin : g_chk_beats
        $error("rf_ldst_engine: beats per line must be in 1..255");
    end

    ldst_state_e             r_state, w_next;
    logic                    r_store;
    logic [SDRAM_ADDR_W-1:0] r_sd_addr, r_stride;
    logic [RF_ADDR_W-1:0]    r_rf_addr;
    logic [7:0]              r_remaining;

    logic                    w_accept, w_load, w_cap, w_adv, w_line_done, w_last, w_last_line;
    logic [RF_DATA_W-1:0]    w_line;
    logic [SDRAM_DATA_W-1:0] w_slice;

    assign w_accept      = (r_state == IDLE) && cmd_valid;
    assign w_last_line   = (r_remaining == 8'd1);
    assign busy          = (r_state != IDLE);
    assign av_byteenable = '1;

    ldst_line_buf #(
        .LINE_W  (RF_DATA_W),
        .SLICE_W (SDRAM_DATA_W),
        .BEATS   (BEATS)
    ) u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_accept),
        .i_load  (w_load),
        .i_slice (av_readdata),
        .i_cap   (w_cap),
        .i_line  (rf_q),
        .i_adv   (w_adv),
        .o_last  (w_last),
        .o_line  (w_line),
        .o_slice (w_slice)
    );

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Command fields latch at acceptance, then step by one line after each finished line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store     <= 1'b0;
            r_sd_addr   <= '0;
            r_stride    <= '0;
            r_rf_addr   <= '0;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_store     <= cmd_store;
            r_sd_addr   <= cmd_sdram_addr;
            r_stride    <= cmd_sdram_stride;
            r_rf_addr   <= cmd_rf_addr;
            r_remaining <= cmd_line_num;
        end else if (w_line_done) begin
            r_sd_addr   <= r_sd_addr + r_stride;
            r_rf_addr   <= r_rf_addr + RF_ADDR_W'(1);
            r_remaining <= r_remaining - 8'd1;
        end
    end

    // Next-state and output decode; every output is a function of the current state.
    // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        w_next        = r_state;
        cmd_ready     = 1'b0;
        done          = 1'b0;
        av_address    = '0;
        av_read       = 1'b0;
        av_write      = 1'b0;
        av_writedata  = '0;
        av_burstcount = 8'd0;
        rf_addr       = '0;
        rf_d          = '0;
        rf_we         = 1'b0;
        rf_re         = 1'b0;
        w_load        = 1'b0;
        w_cap         = 1'b0;
        w_adv         = 1'b0;
        w_line_done   = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_line_num == 8'd0) w_next = FIN;
                    else if (cmd_store)       w_next = RF_RD;
                    else                      w_next = RD_REQ;
                end
            end
            RD_REQ: begin
                av_read       = 1'b1;
                av_address    = r_sd_addr;
                av_burstcount = 8'(BEATS);
                if (!av_waitrequest) w_next = RD_DATA;
            end
            RD_DATA: begin
                if (av_readdatavalid) begin
                    w_load = 1'b1;
                    if (w_last) w_next = RF_WR;
                end
            end
            RF_WR: begin
                rf_we       = 1'b1;
                rf_addr     = r_rf_addr;
                rf_d        = w_line;
                w_line_done = 1'b1;
                w_next      = w_last_line ? FIN : RD_REQ;
            end
            RF_RD: begin
                rf_re   = 1'b1;
                rf_addr = r_rf_addr;
                w_next  = RF_CAP;
            end
            RF_CAP: begin
                w_cap  = 1'b1;
                w_next = WR_BURST;
            end
            WR_BURST: begin
                av_write      = 1'b1;
                av_address    = r_sd_addr;
                av_burstcount = 8'(BEATS);
                av_writedata  = w_slice;
                if (!av_waitrequest) begin
                    w_adv = 1'b1;
                    if (w_last) begin
                        w_line_done = 1'b1;
                        w_next      = w_last_line ? FIN : RF_RD;
                    end
                end
            end
            FIN: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // r_store only steers the IDLE branch through cmd_store; kept for visibility of the active command.
    logic w_store_unused;
    assign w_store_unused = r_store;

endmodule

// File: tb/tb_rf_ldst_engine.sv
// Self-checking bench for rf_ldst_engine: Avalon slave + RF models, scoreboard built from the transfer rules.
module tb_rf_ldst_engine;

    localparam int RF_ADDR_W    = 9;
    localparam int SDRAM_ADDR_W = 32;
    localparam int SDRAM_DATA_W = 128;
    localparam int RF_DATA_W    = 1408;
    localparam int BEATS        = RF_DATA_W / SDRAM_DATA_W;
    localparam int RF_DEPTH     = 1 << RF_ADDR_W;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      cmd_valid, cmd_ready, cmd_store;
    logic [SDRAM_ADDR_W-1:0]   cmd_sdram_addr, cmd_sdram_stride;
    logic [RF_ADDR_W-1:0]      cmd_rf_addr;
    logic [7:0]                cmd_line_num;
    logic                      busy, done;
    logic [SDRAM_ADDR_W-1:0]   av_address;
    logic                      av_read, av_write;
    logic [SDRAM_DATA_W-1:0]   av_writedata;
    logic [SDRAM_DATA_W/8-1:0] av_byteenable;
    logic [7:0]                av_burstcount;
    logic                      av_waitrequest, av_readdatavalid;
    logic [SDRAM_DATA_W-1:0]   av_readdata;
    logic [RF_ADDR_W-1:0]      rf_addr;
    logic [RF_DATA_W-1:0]      rf_d, rf_q;
    logic                      rf_we, rf_re;

    rf_ldst_engine #(
        .RF_ADDR_W(RF_ADDR_W), .SDRAM_ADDR_W(SDRAM_ADDR_W),
        .SDRAM_DATA_W(SDRAM_DATA_W), .RF_DATA_W(RF_DATA_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
        .cmd_sdram_addr(cmd_sdram_addr), .cmd_sdram_stride(cmd_sdram_stride),
        .cmd_rf_addr(cmd_rf_addr), .cmd_line_num(cmd_line_num),
        .busy(busy), .done(done),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_burstcount(av_burstcount), .av_waitrequest(av_waitrequest),
        .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
        .rf_addr(rf_addr), .rf_d(rf_d), .rf_we(rf_we), .rf_re(rf_re), .rf_q(rf_q)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [31:0] addr; logic [7:0] bc; logic [127:0] data; } av_txn_t;
    typedef struct { logic [8:0] addr; logic [RF_DATA_W-1:0] data; } rf_txn_t;

    logic [RF_DATA_W-1:0] rf_mem [RF_DEPTH];   // read-only register-file contents for stores
    av_txn_t              rd_log[$], wr_log[$];
    rf_txn_t              rfw_log[$];
    logic [127:0]         beat_q[$];           // every genuine read beat handed to the DUT, in order
    int                   pending, beats_given, done_cnt, proto_err, ready_busy_err, rfre_cnt;
    int                   wait_mode;           // 0 none, 1 toggle each cycle, 2 random
    bit                   spurious_en;
    logic                 wait_phase, hold, rf_re_d;
    logic [8:0]           rf_addr_d;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [RF_DATA_W-1:0] rand_line();
        logic [RF_DATA_W-1:0] v;
        for (int w = 0; w < RF_DATA_W / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Line i of a command lives at base + i*stride, modulo 2^32.
    function automatic logic [31:0] line_addr(input logic [31:0] base, input logic [31:0] stride, input int i);
        longint s;
        s = longint'(base) + longint'(i) * longint'(stride);
        return 32'(s);
    endfunction

    // RF line i of a command is rf + i, modulo the RF depth.
    function automatic logic [8:0] rf_line(input logic [8:0] rf, input int i);
        return 9'((int'(rf) + i) % RF_DEPTH);
    endfunction

    // Avalon slave, RF and protocol monitor: sample at negedge, drive values for the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 0; av_waitrequest = 1'b0; av_readdatavalid = 1'b0;
            rf_re_d = 1'b0; wait_phase = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (av_read && av_write) proto_err++;
            if ((av_read || av_write) && av_byteenable !== '1) proto_err++;
            if (cmd_ready && busy) ready_busy_err++;
            case (wait_mode)
                0:       hold = 1'b0;
                1:       begin wait_phase = ~wait_phase; hold = wait_phase; end
                default: hold = 1'($urandom_range(0, 1));
            endcase
            av_waitrequest = hold;
            if (pending > 0 && (wait_mode == 0 || $urandom_range(0, 3) != 0)) begin
                av_readdata = rand128(); av_readdatavalid = 1'b1;
                beat_q.push_back(av_readdata); pending--; beats_given++;
            end else if (spurious_en && pending == 0) begin
                av_readdata = rand128(); av_readdatavalid = 1'b1;
            end else begin
                av_readdatavalid = 1'b0;
            end
            if (av_read && !hold) begin
                rd_log.push_back('{av_address, av_burstcount, 128'd0});
                pending += int'(av_burstcount);
            end
            if (av_write && !hold) wr_log.push_back('{av_address, av_burstcount, av_writedata});
            if (rf_we) rfw_log.push_back('{rf_addr, rf_d});
            if (rf_re) rfre_cnt++;
            rf_q = rf_re_d ? rf_mem[rf_addr_d] : rand_line();
            rf_re_d = rf_re; rf_addr_d = rf_addr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        rd_log.delete(); wr_log.delete(); rfw_log.delete(); beat_q.delete();
        beats_given = 0; done_cnt = 0; proto_err = 0; ready_busy_err = 0; rfre_cnt = 0;
    endtask

    task automatic issue_cmd(input bit store, input logic [31:0] addr, input logic [31:0] stride,
                             input logic [8:0] rf, input logic [7:0] lines);
        @(negedge clk);
        cmd_store = store; cmd_sdram_addr = addr; cmd_sdram_stride = stride;
        cmd_rf_addr = rf; cmd_line_num = lines; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin @(posedge clk); #1; n++; end
        checks++;
        if (done_cnt == 0) begin
            failures++; $display("FAIL %s done_timeout: got no done in %0d cycles", tag, budget);
        end
        repeat (2) @(posedge clk); #1;
    endtask

    // Compare everything the monitors recorded against what the command should have produced.
    task automatic score_transfer(input string tag, input bit store, input logic [31:0] addr,
                                  input logic [31:0] stride, input logic [8:0] rf, input int lines);
        int n_rd, n_wr, n_rfw, idx, li, k;
        logic [RF_DATA_W-1:0] exp_line;
        logic [127:0] exp_beat;
        n_rd  = store ? 0 : lines;
        n_wr  = store ? lines * BEATS : 0;
        n_rfw = store ? 0 : lines;
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt); end
        checks++; if (proto_err != 0) begin failures++; $display("FAIL %s avalon_protocol: got %0d errors want 0", tag, proto_err); end
        checks++; if (ready_busy_err != 0) begin failures++; $display("FAIL %s ready_while_busy: got %0d want 0", tag, ready_busy_err); end
        checks++; if (rd_log.size() != n_rd) begin failures++; $display("FAIL %s read_bursts: got %0d want %0d", tag, rd_log.size(), n_rd); end
        checks++; if (wr_log.size() != n_wr) begin failures++; $display("FAIL %s write_beats: got %0d want %0d", tag, wr_log.size(), n_wr); end
        checks++; if (rfw_log.size() != n_rfw) begin failures++; $display("FAIL %s rf_writes: got %0d want %0d", tag, rfw_log.size(), n_rfw); end
        checks++; if (rfre_cnt != (store ? lines : 0)) begin failures++; $display("FAIL %s rf_reads: got %0d want %0d", tag, rfre_cnt, store ? lines : 0); end
        checks++; if (beats_given != n_rd * BEATS) begin failures++; $display("FAIL %s read_beats: got %0d want %0d", tag, beats_given, n_rd * BEATS); end
        for (int i = 0; i < n_rd && i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[i].addr !== line_addr(addr, stride, i) || rd_log[i].bc !== 8'(BEATS)) begin
                failures++;
                $display("FAIL %s rd_burst[%0d]: got addr %h bc %0d want addr %h bc %0d",
                         tag, i, rd_log[i].addr, rd_log[i].bc, line_addr(addr, stride, i), BEATS);
            end
        end
        for (int i = 0; i < n_rfw && i < rfw_log.size(); i++) begin
            for (int b = 0; b < BEATS; b++) begin
                idx = i * BEATS + b;
                exp_line[b*SDRAM_DATA_W +: SDRAM_DATA_W] = (idx < beat_q.size()) ? beat_q[idx] : 128'd0;
            end
            checks++;
            if (rfw_log[i].addr !== rf_line(rf, i) || rfw_log[i].data !== exp_line) begin
                failures++;
                $display("FAIL %s rf_write[%0d]: got addr %0d data %h want addr %0d data %h",
                         tag, i, rfw_log[i].addr, rfw_log[i].data, rf_line(rf, i), exp_line);
            end
        end
        for (int j = 0; j < n_wr && j < wr_log.size(); j++) begin
            li = j / BEATS; k = j % BEATS;
            exp_beat = rf_mem[rf_line(rf, li)][k*SDRAM_DATA_W +: SDRAM_DATA_W];
            checks++;
            if (wr_log[j].addr !== line_addr(addr, stride, li) || wr_log[j].bc !== 8'(BEATS) ||
                wr_log[j].data !== exp_beat) begin
                failures++;
                $display("FAIL %s wr_beat[%0d]: got addr %h bc %0d data %h want addr %h bc %0d data %h",
                         tag, j, wr_log[j].addr, wr_log[j].bc, wr_log[j].data,
                         line_addr(addr, stride, li), BEATS, exp_beat);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); end
        checks++;
        if ({busy, done, av_read, av_write, rf_we, rf_re} !== 6'b0) begin
            failures++; $display("FAIL reset strobes: got %b want 000000", {busy, done, av_read, av_write, rf_we, rf_re});
        end
        checks++;
        if (av_address !== '0 || av_burstcount !== 8'd0 || av_writedata !== '0 || rf_addr !== '0 || rf_d !== '0) begin
            failures++; $display("FAIL reset buses: got addr %h bc %0d rf_addr %0d want all zero", av_address, av_burstcount, rf_addr);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL reset idle_after: got ready %b busy %b want 1 0", cmd_ready, busy); end
    endtask

    task automatic test_load_basic();
        wait_mode = 0; spurious_en = 1'b0; clear_logs();
        issue_cmd(1'b0, 32'h1000, 32'h200, 9'd5, 8'd2);
        wait_done("load_basic", 500);
        score_transfer("load_basic", 1'b0, 32'h1000, 32'h200, 9'd5, 2);
    endtask

    task automatic test_store_wait();
        wait_mode = 1; spurious_en = 1'b0; clear_logs();
        issue_cmd(1'b1, 32'h2000, 32'h100, 9'd3, 8'd1);
        wait_done("store_wait", 500);
        score_transfer("store_wait", 1'b1, 32'h2000, 32'h100, 9'd3, 1);
    endtask

    task automatic test_zero_lines();
        wait_mode = 0; spurious_en = 1'b0; clear_logs();
        issue_cmd(1'b0, 32'h3000, 32'h40, 9'd7, 8'd0);
        // IDLE goes straight to FIN, so done is up in the cycle after acceptance.
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_lines done_timing: got %b want 1", done); end
        repeat (3) @(posedge clk); #1;
        score_transfer("zero_lines", 1'b0, 32'h3000, 32'h40, 9'd7, 0);
    endtask

    task automatic test_rf_wrap();
        wait_mode = 2; spurious_en = 1'b1; clear_logs();
        issue_cmd(1'b0, 32'hFFFF_FF00, 32'h200, 9'd511, 8'd2);
        wait_done("rf_wrap", 1000);
        score_transfer("rf_wrap", 1'b0, 32'hFFFF_FF00, 32'h200, 9'd511, 2);
        checks++;
        if (rfw_log.size() == 2 && rfw_log[1].addr !== 9'd0) begin
            failures++; $display("FAIL rf_wrap second_addr: got %0d want 0", rfw_log[1].addr);
        end
    endtask

    task automatic test_reset_abort();
        int n = 0;
        wait_mode = 0; spurious_en = 1'b0; clear_logs();
        issue_cmd(1'b0, 32'h4000, 32'h200, 9'd10, 8'd2);
        while (beats_given < 5 && n < 200) begin @(posedge clk); #1; n++; end
        checks++; if (beats_given < 5) begin failures++; $display("FAIL abort beats: got %0d want 5", beats_given); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rf_we !== 1'b0) begin
            failures++; $display("FAIL abort in_reset: got ready %b busy %b done %b we %b want 1 0 0 0", cmd_ready, busy, done, rf_we);
        end
        rst_n = 1'b1;
        repeat (20) @(posedge clk); #1;
        checks++;
        if (rfw_log.size() != 0 || done_cnt != 0) begin
            failures++; $display("FAIL abort aftermath: got rf_writes %0d done %0d want 0 0", rfw_log.size(), done_cnt);
        end
        clear_logs();
        issue_cmd(1'b0, 32'h5000, 32'h80, 9'd20, 8'd1);
        wait_done("abort_recover", 500);
        score_transfer("abort_recover", 1'b0, 32'h5000, 32'h80, 9'd20, 1);
    endtask

    task automatic test_cmd_held();
        int n = 0;
        wait_mode = 0; spurious_en = 1'b0; clear_logs();
        @(negedge clk);
        cmd_store = 1'b0; cmd_sdram_addr = 32'h6000; cmd_sdram_stride = 32'h40;
        cmd_rf_addr = 9'd40; cmd_line_num = 8'd1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        // Fields change after acceptance; the transfer must use the latched values.
        cmd_sdram_addr = 32'hDEAD_0000; cmd_rf_addr = 9'd100; cmd_line_num = 8'd3; cmd_store = 1'b1;
        while (done_cnt == 0 && n < 300) begin @(posedge clk); #1; n++; end
        cmd_valid = 1'b0;
        checks++; if (done_cnt == 0) begin failures++; $display("FAIL cmd_held done_timeout: got no done in 300 cycles"); end
        repeat (3) @(posedge clk); #1;
        score_transfer("cmd_held", 1'b0, 32'h6000, 32'h40, 9'd40, 1);
    endtask

    task automatic test_random();
        bit          st;
        logic [31:0] a, s;
        logic [8:0]  r;
        int          nl;
        for (int it = 0; it < 6; it++) begin
            wait_mode = $urandom_range(0, 2); spurious_en = 1'b1; clear_logs();
            st = 1'($urandom_range(0, 1)); a = $urandom; s = $urandom_range(0, 4095) * 16;
            r = 9'($urandom); nl = $urandom_range(1, 3);
            issue_cmd(st, a, s, r, 8'(nl));
            wait_done("random", 1000);
            score_transfer(st ? "random_store" : "random_load", st, a, s, r, nl);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_store = 1'b0;
        cmd_sdram_addr = '0; cmd_sdram_stride = '0; cmd_rf_addr = '0; cmd_line_num = '0;
        av_waitrequest = 1'b0; av_readdatavalid = 1'b0; av_readdata = '0; rf_q = '0;
        wait_mode = 0; spurious_en = 1'b0; wait_phase = 1'b0; rf_re_d = 1'b0; rf_addr_d = '0;
        for (int i = 0; i < RF_DEPTH; i++) rf_mem[i] = rand_line();
        clear_logs();
        test_reset();
        test_load_basic();
        test_store_wait();
        test_zero_lines();
        test_rf_wrap();
        test_reset_abort();
        test_cmd_held();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
